// File: rtl/pe_frame_scheduler_if.sv
// Host/engine-facing signal bundle of the frame scheduler.
// The master is the layer controller; the slave is pe_frame_scheduler.
interface pe_frame_scheduler_if #(
  parameter int unsigned W_SIZE       = 9,
  parameter int unsigned W_CHANNEL    = 9,
  parameter int unsigned W_FRAME_SIZE = 18,
  parameter int unsigned W_DELAY      = 8
);
  logic                    i_start;
  logic [W_SIZE-1:0]       i_width;
  logic [W_SIZE-1:0]       i_height;
  logic [W_CHANNEL-1:0]    i_q_channel;
  logic [W_DELAY-1:0]      i_hsync_delay;

  logic                    c_ctrl_data_run;
  logic                    c_ctrl_hsync_run;
  logic [W_SIZE-1:0]       c_row;
  logic [W_SIZE-1:0]       c_col;
  logic [W_CHANNEL-1:0]    c_chn;
  logic [W_FRAME_SIZE-1:0] c_data_count;
  logic                    c_end_frame;
  logic                    c_is_first_row;
  logic                    c_is_last_row;
  logic                    c_is_first_col;
  logic                    c_is_last_col;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    output i_start, i_width, i_height, i_q_channel, i_hsync_delay,
    input  c_ctrl_data_run, c_ctrl_hsync_run, c_row, c_col, c_chn, c_data_count,
           c_end_frame, c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
           o_busy, o_done
  );

  modport slave (
    input  i_start, i_width, i_height, i_q_channel, i_hsync_delay,
    output c_ctrl_data_run, c_ctrl_hsync_run, c_row, c_col, c_chn, c_data_count,
           c_end_frame, c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
           o_busy, o_done
  );
endinterface

// File: rtl/pe_frame_scheduler.sv
// Frame-scan controller: walks row -> channel tile -> column for one layer,
// inserting an hsync gap before every column sweep. Outputs are a register stage behind the FSM.
module pe_frame_scheduler #(
  parameter int unsigned W_SIZE       = 9,
  parameter int unsigned W_CHANNEL    = 9,
  parameter int unsigned W_FRAME_SIZE = 18,
  parameter int unsigned W_DELAY      = 8
) (
  input logic clk,
  input logic rstn,
  pe_frame_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HSYNC = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t                  state, state_nxt;
  logic [W_SIZE-1:0]       row, row_nxt, col, col_nxt;
  logic [W_CHANNEL-1:0]    chn, chn_nxt;
  logic [W_DELAY-1:0]      gap, gap_nxt;
  logic [W_FRAME_SIZE-1:0] dcnt, dcnt_nxt;
  logic [W_SIZE-1:0]       cfg_w, cfg_w_nxt, cfg_h, cfg_h_nxt;
  logic [W_CHANNEL-1:0]    cfg_q, cfg_q_nxt;
  logic [W_DELAY-1:0]      cfg_d, cfg_d_nxt;
  logic                    last_col, last_chn, last_row, accept;

  // Next-state and counter logic
  always_comb begin
    last_col  = (col == cfg_w - W_SIZE'(1));
    last_chn  = (chn == cfg_q - W_CHANNEL'(1));
    last_row  = (row == cfg_h - W_SIZE'(1));
    // o_done high means the DONE cycle is visible to the host; a start there is dropped
    accept    = bus.i_start && !bus.o_done && (bus.i_width != '0) &&
                (bus.i_height != '0) && (bus.i_q_channel != '0);
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    chn_nxt   = chn;
    gap_nxt   = gap;
    dcnt_nxt  = dcnt;
    cfg_w_nxt = cfg_w;
    cfg_h_nxt = cfg_h;
    cfg_q_nxt = cfg_q;
    cfg_d_nxt = cfg_d;
    case (state)
      IDLE: begin
        if (accept) begin
          cfg_w_nxt = bus.i_width;
          cfg_h_nxt = bus.i_height;
          cfg_q_nxt = bus.i_q_channel;
          cfg_d_nxt = bus.i_hsync_delay;
          row_nxt   = '0;
          col_nxt   = '0;
          chn_nxt   = '0;
          gap_nxt   = '0;
          dcnt_nxt  = '0;
          state_nxt = (bus.i_hsync_delay == '0) ? DATA : HSYNC;
        end
      end
      HSYNC: begin
        if (gap == cfg_d - W_DELAY'(1)) begin
          gap_nxt   = '0;
          state_nxt = DATA;
        end else begin
          gap_nxt = gap + W_DELAY'(1);
        end
      end
      DATA: begin
        dcnt_nxt = dcnt + W_FRAME_SIZE'(1);
        if (last_col) begin
          col_nxt = '0;
          if (last_chn) begin
            chn_nxt = '0;
            row_nxt = row + W_SIZE'(1);
          end else begin
            chn_nxt = chn + W_CHANNEL'(1);
          end
          if (last_row && last_chn) state_nxt = DONE;
          else                      state_nxt = (cfg_d == '0) ? DATA : HSYNC;
        end else begin
          col_nxt = col + W_SIZE'(1);
        end
      end
      DONE: begin
        row_nxt   = '0;
        col_nxt   = '0;
        chn_nxt   = '0;
        dcnt_nxt  = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      chn   <= '0;
      gap   <= '0;
      dcnt  <= '0;
      cfg_w <= '0;
      cfg_h <= '0;
      cfg_q <= '0;
      cfg_d <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      chn   <= chn_nxt;
      gap   <= gap_nxt;
      dcnt  <= dcnt_nxt;
      cfg_w <= cfg_w_nxt;
      cfg_h <= cfg_h_nxt;
      cfg_q <= cfg_q_nxt;
      cfg_d <= cfg_d_nxt;
    end
  end

  // Registered engine controls decoded from the current state and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.c_ctrl_data_run  <= 1'b0;
      bus.c_ctrl_hsync_run <= 1'b0;
      bus.c_row            <= '0;
      bus.c_col            <= '0;
      bus.c_chn            <= '0;
      bus.c_data_count     <= '0;
      bus.c_end_frame      <= 1'b0;
      bus.c_is_first_row   <= 1'b0;
      bus.c_is_last_row    <= 1'b0;
      bus.c_is_first_col   <= 1'b0;
      bus.c_is_last_col    <= 1'b0;
      bus.o_busy           <= 1'b0;
      bus.o_done           <= 1'b0;
    end else begin
      bus.c_ctrl_data_run  <= (state == DATA);
      bus.c_ctrl_hsync_run <= (state == HSYNC);
      bus.o_busy           <= (state == DATA) || (state == HSYNC);
      bus.o_done           <= (state == DONE);
      bus.c_row            <= ((state == DATA) || (state == HSYNC)) ? row : '0;
      bus.c_chn            <= ((state == DATA) || (state == HSYNC)) ? chn : '0;
      bus.c_col            <= (state == DATA) ? col : '0;
      bus.c_end_frame      <= (state == DATA) && last_row && last_chn && last_col;
      bus.c_is_first_row   <= (state == DATA) && (row == '0);
      bus.c_is_last_row    <= (state == DATA) && last_row;
      bus.c_is_first_col   <= (state == DATA) && (col == '0);
      bus.c_is_last_col    <= (state == DATA) && last_col;
      // beat index holds through hsync gaps, clears outside a frame
      if (state == DATA)                        bus.c_data_count <= dcnt;
      else if ((state == IDLE) || (state == DONE)) bus.c_data_count <= '0;
    end
  end
endmodule

// File: tb/tb_pe_frame_scheduler.sv
// Directed self-checking bench for pe_frame_scheduler.
module tb_pe_frame_scheduler;
  localparam int unsigned W_SIZE       = 9;
  localparam int unsigned W_CHANNEL    = 9;
  localparam int unsigned W_FRAME_SIZE = 18;
  localparam int unsigned W_DELAY      = 8;
  localparam int          BUDGET       = 2000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pe_frame_scheduler_if #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .W_FRAME_SIZE(W_FRAME_SIZE), .W_DELAY(W_DELAY)
  ) bus ();

  pe_frame_scheduler #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .W_FRAME_SIZE(W_FRAME_SIZE), .W_DELAY(W_DELAY)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.c_ctrl_data_run, bus.c_ctrl_hsync_run, bus.c_row, bus.c_col, bus.c_chn,
                bus.c_data_count, bus.c_end_frame, bus.c_is_first_row, bus.c_is_last_row,
                bus.c_is_first_col, bus.c_is_last_col, bus.o_busy, bus.o_done});
  endfunction

  task automatic drive_cfg(input int w, input int h, input int q, input int d);
    bus.i_width       = W_SIZE'(w);
    bus.i_height      = W_SIZE'(h);
    bus.i_q_channel   = W_CHANNEL'(q);
    bus.i_hsync_delay = W_DELAY'(d);
  endtask

  // Runs one frame, tracking the expected scan order with a small model; returns at the o_done cycle.
  task automatic run_frame(input int w, input int h, input int q, input int d, input bit extra,
                           input int exp_beats, input int exp_hsync, input int exp_lat);
    int  n, beats, hs, busy_n, lat;
    int  er, ec, ecol, ecnt;
    bit  done_seen;
    n = 0; beats = 0; hs = 0; busy_n = 0; lat = -1;
    er = 0; ec = 0; ecol = 0; ecnt = 0; done_seen = 0;
    drive_cfg(w, h, q, d);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    drive_cfg(w + 3, h + 2, q + 1, d + 5);
    while (!done_seen && n < BUDGET) begin
      bus.i_start = (extra && n == 3);
      step();
      n++;
      if (bus.o_busy) busy_n++;
      if (bus.c_ctrl_hsync_run) begin
        hs++;
        check("hsync_coord", 64'({bus.c_ctrl_data_run, bus.c_row, bus.c_chn, bus.c_col}),
              64'({1'b0, W_SIZE'(er), W_CHANNEL'(ec), W_SIZE'(0)}));
      end
      if (bus.c_ctrl_data_run) begin
        beats++;
        check("beat_coord", 64'({bus.c_row, bus.c_chn, bus.c_col, bus.c_data_count}),
              64'({W_SIZE'(er), W_CHANNEL'(ec), W_SIZE'(ecol), W_FRAME_SIZE'(ecnt)}));
        check("beat_flags", 64'({bus.c_is_first_row, bus.c_is_last_row, bus.c_is_first_col,
                                 bus.c_is_last_col, bus.c_end_frame}),
              64'({er == 0, er == h - 1, ecol == 0, ecol == w - 1,
                   (er == h - 1) && (ec == q - 1) && (ecol == w - 1)}));
        ecnt++;
        if (ecol == w - 1) begin
          ecol = 0;
          if (ec == q - 1) begin ec = 0; er++; end
          else ec++;
        end else begin
          ecol++;
        end
      end else begin
        check("idle_flags", 64'({bus.c_is_first_row, bus.c_is_last_row, bus.c_is_first_col,
                                 bus.c_is_last_col, bus.c_end_frame}), 64'(0));
      end
      if (bus.o_done) begin
        done_seen = 1;
        lat = n;
        check("done_state", 64'({bus.o_busy, bus.c_ctrl_data_run, bus.c_ctrl_hsync_run,
                                 bus.c_row, bus.c_col, bus.c_chn}), 64'(0));
      end
    end
    bus.i_start = 1'b0;
    if (!done_seen) check("timeout", 64'(0), 64'(1));
    check("beats", 64'(beats), 64'(exp_beats));
    check("hsync_cycles", 64'(hs), 64'(exp_hsync));
    check("busy_cycles", 64'(busy_n), 64'(exp_beats + exp_hsync));
    check("done_latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    bus.i_start = 1'b0;
    drive_cfg(0, 0, 0, 0);
    #1;
    check("reset_outs", all_outs(), 64'(0));
    step();
    step();
    rstn = 1'b1;
    step();
    check("post_reset_outs", all_outs(), 64'(0));

    // 4x2, 2 channel tiles, 3-cycle gap; config scrambled after accept
    run_frame(4, 2, 2, 3, 0, 16, 12, 29);
    step();
    check("done_pulse_len", 64'(bus.o_done), 64'(0));

    // same frame without gaps: sweeps back to back
    run_frame(4, 2, 2, 0, 0, 16, 0, 17);
    step();

    // 1x1x1 frame; start offered in the o_done cycle is dropped
    run_frame(1, 1, 1, 2, 0, 1, 2, 4);
    drive_cfg(2, 2, 2, 1);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    check("start_in_done", 64'({bus.o_busy, bus.o_done, bus.c_ctrl_hsync_run, bus.c_ctrl_data_run}), 64'(0));
    step();
    check("start_in_done_2", 64'({bus.o_busy, bus.c_ctrl_hsync_run, bus.c_ctrl_data_run}), 64'(0));

    // zero width is rejected
    drive_cfg(0, 2, 2, 1);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("zero_cfg", all_outs(), 64'(0));
    end

    // second start while busy is ignored
    run_frame(3, 2, 1, 1, 1, 6, 2, 9);
    step();

    // reset during a row-1 beat aborts the frame
    drive_cfg(4, 2, 2, 3);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    n = 0;
    while (!(bus.c_ctrl_data_run && bus.c_row == W_SIZE'(1)) && n < BUDGET) begin
      step();
      n++;
    end
    check("reach_row1", 64'(n < BUDGET), 64'(1));
    rstn = 1'b0;
    #1;
    check("abort_outs", all_outs(), 64'(0));
    step();
    check("abort_outs_clk", all_outs(), 64'(0));
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_done", 64'({bus.o_done, bus.o_busy}), 64'(0));
    end

    // fresh frame after the abort starts from beat 0
    run_frame(4, 2, 2, 3, 0, 16, 12, 29);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
